// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO drain path: stack geometry, reader FSM
// states and the output-side credit limit.
package lifo_pkg;

  localparam int LIFO_DWIDTH  = 16;
  localparam int LIFO_AWIDTH  = 8;
  localparam int CREDIT_LIMIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/lifo_skid_buf.sv
// Two-entry in-order output buffer; the MSB of each entry is the last tag,
// which can be set on the newest surviving entry via mark_last.
module lifo_skid_buf #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         mark_last,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] mem0, mem1, nxt0, nxt1;
  logic [1:0]   cnt, cnt_n;

  always_comb begin
    nxt0  = mem0;
    nxt1  = mem1;
    cnt_n = cnt;
    case ({push, pop})
      2'b10: begin
        if (cnt == 2'd0) begin
          nxt0  = din;
          cnt_n = 2'd1;
        end else if (cnt == 2'd1) begin
          nxt1  = din;
          cnt_n = 2'd2;
        end
      end
      2'b01: begin
        if (cnt != 2'd0) begin
          nxt0  = mem1;
          cnt_n = cnt - 2'd1;
        end
      end
      2'b11: begin
        if (cnt == 2'd1) begin
          nxt0 = din;
        end else if (cnt == 2'd2) begin
          nxt0 = mem1;
          nxt1 = din;
        end else begin
          nxt0  = din;
          cnt_n = 2'd1;
        end
      end
      default: ;
    endcase
    // Retag applies after this cycle's pop so an entry leaving now is untouched.
    if (mark_last) begin
      if (cnt_n == 2'd2)      nxt1[W-1] = 1'b1;
      else if (cnt_n == 2'd1) nxt0[W-1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mem0 <= '0;
      mem1 <= '0;
      cnt  <= 2'd0;
    end else begin
      mem0 <= nxt0;
      mem1 <= nxt1;
      cnt  <= cnt_n;
    end
  end

  assign dout  = mem0;
  assign valid = (cnt != 2'd0);
  assign count = cnt;

endmodule

// File: rtl/lifo_reader.sv
// Drains a LIFO onto a valid/ready stream, either a fixed word count or until
// empty, tagging the final word with last and pulsing done at the end.
module lifo_reader
  import lifo_pkg::*;
#(
  parameter int DWIDTH = LIFO_DWIDTH,
  parameter int AWIDTH = LIFO_AWIDTH
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              start_i,
  input  logic [AWIDTH:0]   count_i,
  output logic              rdreq_o,
  input  logic [DWIDTH-1:0] q_i,
  input  logic              empty_i,
  input  logic [AWIDTH:0]   usedw_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o,
  output state_t            state_o
);

  // Stream handshake: a word moves when valid_o && ready_i at a rising edge;
  // once valid_o is high, data_o/last_o hold until that transfer happens.

  localparam logic [AWIDTH:0] ONE   = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [2:0]      LIMIT = 3'(CREDIT_LIMIT);

  state_t            state;
  logic [AWIDTH:0]   remaining;
  logic              drain_all;
  logic              inflight;
  logic              inflight_last;
  logic [DWIDTH:0]   buf_dout;
  logic              buf_valid;
  logic [1:0]        occ;
  logic [2:0]        pending;
  logic              xfer, credit_ok, issue, tag_last, early_empty;

  assign xfer      = buf_valid & ready_i;
  assign pending   = {1'b0, occ} + {2'b00, inflight};
  // A slot freed by this cycle's transfer may be reused by this cycle's pop.
  assign credit_ok = (pending < LIMIT) || ((pending == LIMIT) && xfer);
  assign issue     = (state == ST_READ) && !empty_i
                     && ((remaining != '0) || drain_all) && credit_ok;
  assign tag_last  = (remaining == ONE) || (usedw_i == ONE);
  assign early_empty = (state == ST_READ) && empty_i && !inflight;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state         <= ST_IDLE;
      remaining     <= '0;
      drain_all     <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_last <= tag_last;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            remaining <= count_i;
            drain_all <= (count_i == '0);
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          if (issue) begin
            if (!drain_all) remaining <= remaining - ONE;
            if (tag_last) state <= ST_FLUSH;
          end else if (early_empty) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (!inflight && (occ == 2'd0)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  lifo_skid_buf #(.W(DWIDTH + 1)) u_skid (
    .clk       (clk_i),
    .arst_n    (arst_n_i),
    .push      (inflight),
    .din       ({inflight_last, q_i}),
    .pop       (xfer),
    .mark_last (early_empty),
    .dout      (buf_dout),
    .valid     (buf_valid),
    .count     (occ)
  );

  assign rdreq_o = issue;
  assign data_o  = buf_dout[DWIDTH-1:0];
  assign valid_o = buf_valid;
  assign last_o  = buf_valid & buf_dout[DWIDTH];
  assign busy_o  = (state != ST_IDLE);
  assign done_o  = (state == ST_DONE);
  assign state_o = state;

endmodule

// File: tb/tb_lifo_reader.sv
// Bench for lifo_reader: a behavioural LIFO feeds the DUT and a reference
// stack predicts the drained stream in pop order.
module tb_lifo_reader;
  import lifo_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  // clock / reset
  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  logic          start_i, ready_i, rdreq_o, empty_i, valid_o, last_o, busy_o, done_o;
  logic [AW:0]   count_i, usedw_i;
  logic [DW-1:0] q_i = '0;
  logic [DW-1:0] data_o;
  state_t        state_dbg;

  lifo_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .start_i  (start_i),
    .count_i  (count_i),
    .rdreq_o  (rdreq_o),
    .q_i      (q_i),
    .empty_i  (empty_i),
    .usedw_i  (usedw_i),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .last_o   (last_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .state_o  (state_dbg)
  );

  // behavioural LIFO: registered read, fill level follows each pop by one edge
  logic [DW-1:0] stk [DEPTH];
  int            sp = 0;
  logic          push_en, lifo_clr;
  logic [DW-1:0] push_data;

  always @(posedge clk) begin
    if (lifo_clr) sp <= 0;
    else if (push_en && sp < DEPTH) begin
      stk[sp] <= push_data;
      sp      <= sp + 1;
    end else if (rdreq_o && sp > 0) begin
      q_i <= stk[sp-1];
      sp  <= sp - 1;
    end
  end
  assign empty_i = (sp == 0);
  assign usedw_i = 9'(sp);

  // reference stack and scoreboard
  logic [DW-1:0] ref_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_d[$];
  logic          obs_l[$];
  int            obs_k[$];
  int n_cmp, n_fail;
  int n_done, n_rdreq, v_empty, v_credit, v_stable, first_valid, done_k;
  bit timed_out;

  // driver tasks
  task automatic lifo_clear();
    @(posedge clk); #1 lifo_clr = 1'b1;
    @(posedge clk); #1 lifo_clr = 1'b0;
    ref_q.delete();
  endtask

  task automatic push_words(input int n, input int base, input bit rnd);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      push_en   = 1'b1;
      push_data = rnd ? 16'($urandom) : 16'(base + i);
      ref_q.push_back(push_data);
      @(posedge clk); #1;
    end
    push_en = 1'b0;
  endtask

  // Expected stream: the top words of the stack, newest first.
  task automatic build_exp(input int cnt);
    int n;
    exp_q.delete();
    n = (cnt == 0 || cnt > ref_q.size()) ? ref_q.size() : cnt;
    repeat (n) exp_q.push_back(ref_q.pop_back());
  endtask

  // Runs one drain, recording transfers and protocol observations.
  task automatic run_drain(input logic [AW:0] cnt, input int ready_pct,
                           input int poke_k, input int max_cyc);
    int popped, xferred;
    bit xfer, prev_v, prev_r, prev_l, finished;
    logic [DW-1:0] prev_d;
    obs_d.delete(); obs_l.delete(); obs_k.delete();
    n_done = 0; n_rdreq = 0; v_empty = 0; v_credit = 0; v_stable = 0;
    first_valid = -1; done_k = -1; timed_out = 0;
    popped = 0; xferred = 0; prev_v = 0; prev_r = 0; prev_l = 0; prev_d = '0;
    finished = 0;
    @(posedge clk); #1;
    start_i = 1'b1; count_i = cnt;
    ready_i = ($urandom_range(0, 99) < ready_pct);
    @(posedge clk); #1;
    start_i = 1'b0;
    ready_i = ($urandom_range(0, 99) < ready_pct);
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      xfer = valid_o && ready_i;
      if (prev_v && !prev_r && (!valid_o || data_o !== prev_d || last_o !== prev_l))
        v_stable++;
      if (rdreq_o) begin
        n_rdreq++;
        if (empty_i) v_empty++;
        if ((popped - xferred) >= 2 && !xfer) v_credit++;
        popped++;
      end
      if (xfer) begin
        obs_d.push_back(data_o); obs_l.push_back(last_o); obs_k.push_back(k);
        xferred++;
      end
      if (valid_o && first_valid < 0) first_valid = k - 1;
      if (done_o) begin
        n_done++;
        if (done_k < 0) done_k = k - 1;
      end
      prev_v = valid_o; prev_r = ready_i; prev_d = data_o; prev_l = last_o;
      if (n_done > 0 && !done_o && !busy_o) begin
        finished = 1;
        break;
      end
      @(posedge clk); #1;
      start_i = (k == poke_k);
      if (k == poke_k) count_i = 9'd1;
      ready_i = ($urandom_range(0, 99) < ready_pct);
    end
    start_i = 1'b0;
    if (!finished) timed_out = 1;
  endtask

  // tests
  task automatic test_reset();
    #1 arst_n = 1'b0;
    #1;
    n_cmp++; if ({rdreq_o, valid_o, last_o, busy_o, done_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {rdreq_o, valid_o, last_o, busy_o, done_o});
    end
    n_cmp++; if (data_o !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0000", data_o);
    end
    n_cmp++; if (state_dbg !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) arst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_idle: got busy=%b valid=%b expected 0/0", busy_o, valid_o);
    end
  endtask

  task automatic test_drain_all();
    lifo_clear(); push_words(8, 1, 0); build_exp(0);
    run_drain('0, 100, 0, 100);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL drain_all_timeout: got timeout expected done"); end
    n_cmp++; if (obs_d.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL drain_all_count: got %0d expected %0d", obs_d.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_d.size(); i++) begin
      n_cmp++; if (obs_d[i] !== exp_q[i] || obs_l[i] !== (i == exp_q.size() - 1)) begin
        n_fail++; $display("FAIL drain_all_word%0d: got %h/%b expected %h/%b", i, obs_d[i], obs_l[i], exp_q[i], (i == exp_q.size() - 1));
      end
    end
    n_cmp++; if (first_valid !== 2) begin
      n_fail++; $display("FAIL drain_all_latency: got %0d expected 2", first_valid);
    end
    n_cmp++; if (obs_k.size() != 8 || (obs_k[7] - obs_k[0]) !== 7) begin
      n_fail++; $display("FAIL drain_all_throughput: got %0d words spread %0d expected 8 over 7", obs_k.size(), obs_k.size() ? obs_k[obs_k.size()-1] - obs_k[0] : -1);
    end
    n_cmp++; if (n_done !== 1 || v_empty !== 0 || n_rdreq !== 8) begin
      n_fail++; $display("FAIL drain_all_ctrl: got done=%0d rdreq_empty=%0d rdreq=%0d expected 1/0/8", n_done, v_empty, n_rdreq);
    end
    n_cmp++; if (usedw_i !== 9'd0) begin
      n_fail++; $display("FAIL drain_all_usedw: got %0d expected 0", usedw_i);
    end
  endtask

  task automatic test_count3();
    lifo_clear(); push_words(256, 0, 1); build_exp(3);
    run_drain(9'd3, 100, 0, 200);
    n_cmp++; if (timed_out || obs_d.size() !== 3) begin
      n_fail++; $display("FAIL count3_count: got %0d timeout=%0b expected 3", obs_d.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < obs_d.size(); i++) begin
      n_cmp++; if (obs_d[i] !== exp_q[i] || obs_l[i] !== (i == 2)) begin
        n_fail++; $display("FAIL count3_word%0d: got %h/%b expected %h/%b", i, obs_d[i], obs_l[i], exp_q[i], (i == 2));
      end
    end
    n_cmp++; if (usedw_i !== 9'd253 || n_rdreq !== 3 || n_done !== 1) begin
      n_fail++; $display("FAIL count3_usedw: got usedw=%0d rdreq=%0d done=%0d expected 253/3/1", usedw_i, n_rdreq, n_done);
    end
  endtask

  task automatic test_empty();
    lifo_clear(); build_exp(0);
    run_drain('0, 100, 0, 20);
    n_cmp++; if (obs_d.size() !== 0 || first_valid !== -1 || n_rdreq !== 0) begin
      n_fail++; $display("FAIL empty_quiet: got words=%0d first_valid=%0d rdreq=%0d expected 0/-1/0", obs_d.size(), first_valid, n_rdreq);
    end
    n_cmp++; if (n_done !== 1 || done_k < 0 || done_k > 3) begin
      n_fail++; $display("FAIL empty_done: got pulses=%0d at=%0d expected 1 within 3", n_done, done_k);
    end
  endtask

  task automatic test_random_ready();
    lifo_clear(); push_words(16, 0, 1); build_exp(0);
    run_drain('0, 50, 4, 400);
    n_cmp++; if (timed_out || obs_d.size() !== 16) begin
      n_fail++; $display("FAIL rnd_ready_count: got %0d timeout=%0b expected 16", obs_d.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < obs_d.size(); i++) begin
      n_cmp++; if (obs_d[i] !== exp_q[i] || obs_l[i] !== (i == 15)) begin
        n_fail++; $display("FAIL rnd_ready_word%0d: got %h/%b expected %h/%b", i, obs_d[i], obs_l[i], exp_q[i], (i == 15));
      end
    end
    n_cmp++; if (v_stable !== 0 || v_credit !== 0 || v_empty !== 0) begin
      n_fail++; $display("FAIL rnd_ready_protocol: got stable=%0d credit=%0d empty=%0d expected 0/0/0", v_stable, v_credit, v_empty);
    end
    n_cmp++; if (n_done !== 1) begin
      n_fail++; $display("FAIL rnd_ready_done: got %0d expected 1", n_done);
    end
  endtask

  task automatic test_count_over();
    lifo_clear(); push_words(4, 0, 1); build_exp(10);
    run_drain(9'd10, 70, 0, 100);
    n_cmp++; if (timed_out || obs_d.size() !== 4) begin
      n_fail++; $display("FAIL count_over_count: got %0d timeout=%0b expected 4", obs_d.size(), timed_out);
    end
    for (int i = 0; i < exp_q.size() && i < obs_d.size(); i++) begin
      n_cmp++; if (obs_d[i] !== exp_q[i] || obs_l[i] !== (i == 3)) begin
        n_fail++; $display("FAIL count_over_word%0d: got %h/%b expected %h/%b", i, obs_d[i], obs_l[i], exp_q[i], (i == 3));
      end
    end
    n_cmp++; if (n_done !== 1 || usedw_i !== 9'd0 || v_empty !== 0) begin
      n_fail++; $display("FAIL count_over_ctrl: got done=%0d usedw=%0d rdreq_empty=%0d expected 1/0/0", n_done, usedw_i, v_empty);
    end
  endtask

  task automatic test_reset_mid_drain();
    int xf, popped;
    bit hit;
    lifo_clear(); push_words(20, 16'h0100, 0);
    @(posedge clk); #1;
    start_i = 1'b1; count_i = '0; ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    xf = 0; popped = 0; hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (rdreq_o) popped++;
      if (valid_o && ready_i) xf++;
      if (xf == 5) hit = 1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #2 arst_n = 1'b0;
    #1;
    n_cmp++; if (!hit) begin n_fail++; $display("FAIL mid_reset_reach: got %0d transfers expected 5", xf); end
    n_cmp++; if ({rdreq_o, valid_o, last_o, busy_o, done_o} !== 5'b0 || data_o !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %b data=%h expected 00000 data=0000", {rdreq_o, valid_o, last_o, busy_o, done_o}, data_o);
    end
    n_cmp++; if (popped < 5 || popped > 7) begin
      n_fail++; $display("FAIL mid_reset_popped: got %0d expected 5..7", popped);
    end
    repeat (popped) void'(ref_q.pop_back());
    @(negedge clk) arst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (busy_o !== 1'b0 || usedw_i !== 9'(ref_q.size())) begin
      n_fail++; $display("FAIL mid_reset_idle: got busy=%b usedw=%0d expected 0/%0d", busy_o, usedw_i, ref_q.size());
    end
    build_exp(0);
    run_drain('0, 100, 0, 100);
    n_cmp++; if (timed_out || obs_d.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL mid_reset_count: got %0d expected %0d", obs_d.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_d.size(); i++) begin
      n_cmp++; if (obs_d[i] !== exp_q[i] || obs_l[i] !== (i == exp_q.size() - 1)) begin
        n_fail++; $display("FAIL mid_reset_word%0d: got %h/%b expected %h/%b", i, obs_d[i], obs_l[i], exp_q[i], (i == exp_q.size() - 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, c, pct, bad;
    for (int it = 0; it < 6; it++) begin
      lifo_clear();
      n   = $urandom_range(0, 40);
      c   = $urandom_range(0, 50);
      pct = $urandom_range(40, 100);
      push_words(n, 0, 1); build_exp(c);
      run_drain(9'(c), pct, 0, 1000);
      n_cmp++; if (timed_out || obs_d.size() !== exp_q.size() || n_done !== 1) begin
        n_fail++; $display("FAIL b2b%0d_count: got %0d done=%0d expected %0d done=1", it, obs_d.size(), n_done, exp_q.size());
      end
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < obs_d.size(); i++)
        if (obs_d[i] !== exp_q[i] || obs_l[i] !== (i == exp_q.size() - 1)) bad++;
      n_cmp++; if (bad !== 0 || v_stable + v_credit + v_empty !== 0) begin
        n_fail++; $display("FAIL b2b%0d_stream: got %0d bad words, %0d protocol errors expected 0/0", it, bad, v_stable + v_credit + v_empty);
      end
    end
  endtask

  initial begin
    arst_n = 1'b1; start_i = 1'b0; count_i = '0; ready_i = 1'b0;
    push_en = 1'b0; push_data = '0; lifo_clr = 1'b0;
    n_cmp = 0; n_fail = 0;
    test_reset();
    test_drain_all();
    test_count3();
    test_empty();
    test_random_ready();
    test_count_over();
    test_reset_mid_drain();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
